// File: rtl/gate_chk_pkg.sv
// Shared defaults and helpers for the gate response checker and its stimulus driver.
// sat_inc is width-agnostic up to 32 bits; callers cast in and out of it.
package gate_chk_pkg;

  localparam int DEF_OUT_W = 2;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 16;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/gate_resp_fifo.sv
// Expected-value FIFO with combinational head read and an occupancy count.
// A push into a full FIFO is accepted only when the same cycle also pops.
module gate_resp_fifo
  import gate_chk_pkg::*;
#(
  parameter int W     = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/gate_resp_checker.sv
// Compares observed gate outputs against queued expectations, counting
// passes/fails and capturing the first mismatch; empty-queue bypass supported.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      exp_valid,
  input  logic [OUT_W-1:0]          exp_data,
  input  logic                      obs_valid,
  input  logic [OUT_W-1:0]          obs_data,
  output logic [$clog2(DEPTH):0]    pending,
  output logic [CNT_W-1:0]          pass_cnt,
  output logic [CNT_W-1:0]          fail_cnt,
  output logic                      fail_seen,
  output logic [CNT_W-1:0]          first_idx,
  output logic [OUT_W-1:0]          first_exp,
  output logic [OUT_W-1:0]          first_obs,
  output logic                      overflow,
  output logic                      underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OUT_W-1:0] w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_push;
  logic             w_cmp_valid;
  logic [OUT_W-1:0] w_cmp_exp;
  logic             w_match;
  logic             w_underflow_evt;
  logic             w_overflow_evt;
  logic [CNT_W:0]   w_idx_sum;
  logic [CNT_W-1:0] w_idx;
  logic [CNT_W-1:0] w_pass_inc;
  logic [CNT_W-1:0] w_fail_inc;

  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_fail_seen;
  logic [CNT_W-1:0] r_first_idx;
  logic [OUT_W-1:0] r_first_exp;
  logic [OUT_W-1:0] r_first_obs;
  logic             r_overflow;
  logic             r_underflow;

  // Bypass case (empty queue, both valid) must not also enqueue the expectation.
  assign w_push = exp_valid && !(obs_valid && w_fifo_empty);

  gate_resp_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_push  (w_push),
    .i_wdata (exp_data),
    .i_pop   (obs_valid),
    .o_rdata (w_head),
    .o_count (pending),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_cmp_valid     = obs_valid && (!w_fifo_empty || exp_valid);
  assign w_cmp_exp       = w_fifo_empty ? exp_data : w_head;
  assign w_match         = (w_cmp_exp == obs_data);
  assign w_underflow_evt = obs_valid && w_fifo_empty && !exp_valid;
  assign w_overflow_evt  = exp_valid && w_fifo_full && !obs_valid;

  assign w_idx_sum  = {1'b0, r_pass_cnt} + {1'b0, r_fail_cnt};
  assign w_idx      = w_idx_sum[CNT_W] ? CNT_MAX : w_idx_sum[CNT_W-1:0];
  assign w_pass_inc = CNT_W'(sat_inc(32'(r_pass_cnt), 32'(CNT_MAX)));
  assign w_fail_inc = CNT_W'(sat_inc(32'(r_fail_cnt), 32'(CNT_MAX)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_fail_seen <= 1'b0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_obs <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_fail_seen <= 1'b0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_obs <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_overflow_evt)  r_overflow  <= 1'b1;
      if (w_underflow_evt) r_underflow <= 1'b1;
      if (w_cmp_valid) begin
        if (w_match) begin
          r_pass_cnt <= w_pass_inc;
        end else begin
          r_fail_cnt  <= w_fail_inc;
          r_fail_seen <= 1'b1;
          if (!r_fail_seen) begin
            r_first_idx <= w_idx;
            r_first_exp <= w_cmp_exp;
            r_first_obs <= obs_data;
          end
        end
      end
    end
  end

  assign pass_cnt  = r_pass_cnt;
  assign fail_cnt  = r_fail_cnt;
  assign fail_seen = r_fail_seen;
  assign first_idx = r_first_idx;
  assign first_exp = r_first_exp;
  assign first_obs = r_first_obs;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Randomised and directed bench for gate_resp_checker: two instances (16-bit and
// 4-bit counters) share stimulus and are compared every cycle to a queue model.
module tb_gate_resp_checker;

  localparam int DEPTH = 8;
  localparam longint MAX16 = 65535;
  localparam longint MAX4  = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       exp_valid = 1'b0;
  logic [1:0] exp_data = '0;
  logic       obs_valid = 1'b0;
  logic [1:0] obs_data = '0;

  logic [3:0]  a_pending, b_pending;
  logic [15:0] a_pass, a_fail, a_idx;
  logic [3:0]  b_pass, b_fail, b_idx;
  logic        a_seen, b_seen, a_ovf, b_ovf, a_unf, b_unf;
  logic [1:0]  a_fexp, a_fobs, b_fexp, b_fobs;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  gate_resp_checker #(.OUT_W(2), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .obs_valid(obs_valid), .obs_data(obs_data),
    .pending(a_pending), .pass_cnt(a_pass), .fail_cnt(a_fail),
    .fail_seen(a_seen), .first_idx(a_idx), .first_exp(a_fexp),
    .first_obs(a_fobs), .overflow(a_ovf), .underflow(a_unf)
  );

  gate_resp_checker #(.OUT_W(2), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .obs_valid(obs_valid), .obs_data(obs_data),
    .pending(b_pending), .pass_cnt(b_pass), .fail_cnt(b_fail),
    .fail_seen(b_seen), .first_idx(b_idx), .first_exp(b_fexp),
    .first_obs(b_fobs), .overflow(b_ovf), .underflow(b_unf)
  );

  // Model keeps exact (unsaturated) totals; each instance sees them clipped to its max.
  int     m_q[$];
  longint m_pass, m_fail, m_idx;
  bit     m_seen, m_ovf, m_unf;
  int     m_fexp, m_fobs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_q.delete();
      m_pass = 0; m_fail = 0; m_idx = 0;
      m_seen = 0; m_ovf = 0; m_unf = 0;
      m_fexp = 0; m_fobs = 0;
    end else begin : model_step
      bit cmp;
      int e;
      cmp = 0;
      e = 0;
      if (obs_valid) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          cmp = 1;
          if (exp_valid) m_q.push_back(int'(exp_data));
        end else if (exp_valid) begin
          e = int'(exp_data);
          cmp = 1;
        end else begin
          m_unf = 1;
        end
      end else if (exp_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(int'(exp_data));
        else m_ovf = 1;
      end
      if (cmp) begin
        if (e == int'(obs_data)) begin
          m_pass++;
        end else begin
          if (!m_seen) begin
            m_idx  = m_pass + m_fail;
            m_fexp = e;
            m_fobs = int'(obs_data);
          end
          m_fail++;
          m_seen = 1;
        end
      end
    end
  end

  function automatic longint clip(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_pending", a_pending, m_q.size());
      chk("a_pass",    a_pass,    clip(m_pass, MAX16));
      chk("a_fail",    a_fail,    clip(m_fail, MAX16));
      chk("a_seen",    a_seen,    m_seen);
      chk("a_idx",     a_idx,     clip(m_idx, MAX16));
      chk("a_fexp",    a_fexp,    m_fexp);
      chk("a_fobs",    a_fobs,    m_fobs);
      chk("a_ovf",     a_ovf,     m_ovf);
      chk("a_unf",     a_unf,     m_unf);
      chk("b_pending", b_pending, m_q.size());
      chk("b_pass",    b_pass,    clip(m_pass, MAX4));
      chk("b_fail",    b_fail,    clip(m_fail, MAX4));
      chk("b_seen",    b_seen,    m_seen);
      chk("b_idx",     b_idx,     clip(m_idx, MAX4));
      chk("b_fexp",    b_fexp,    m_fexp);
      chk("b_fobs",    b_fobs,    m_fobs);
      chk("b_ovf",     b_ovf,     m_ovf);
      chk("b_unf",     b_unf,     m_unf);
    end
  end

  task automatic step(bit ev, logic [1:0] ed, bit ov, logic [1:0] od, bit clr);
    exp_valid = ev;
    exp_data  = ed;
    obs_valid = ov;
    obs_data  = od;
    clear     = clr;
    @(negedge clk);
  endtask

  function automatic logic [1:0] wv(int j);
    return 2'((j * 3 + 1) % 4);
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pending", a_pending, 0);
    chk("rst_pass", a_pass, 0);

    // Mid-run async reset.
    step(0, 2'b00, 0, 2'b00, 1);
    step(1, 2'b01, 0, 2'b00, 0);
    step(1, 2'b10, 0, 2'b00, 0);
    step(1, 2'b11, 0, 2'b00, 0);
    step(1, 2'b00, 0, 2'b00, 0);
    step(0, 2'b00, 1, 2'b11, 0);
    step(0, 2'b00, 0, 2'b00, 0);
    chk("s1_pending_pre", a_pending, 3);
    chk("s1_fail_pre", a_fail, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s1_async_pending", a_pending, 0);
    chk("s1_async_fail", a_fail, 0);
    chk("s1_async_seen", a_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 2'b01, 1, 2'b01, 0);
    chk("s1_bypass_pass", a_pass, 1);
    $display("scenario 1 (async reset, bypass) done");

    // Ordered compare with a single mismatch.
    step(0, 2'b00, 0, 2'b00, 1);
    step(1, 2'b01, 0, 2'b00, 0);
    step(1, 2'b10, 0, 2'b00, 0);
    step(1, 2'b11, 0, 2'b00, 0);
    step(0, 2'b00, 1, 2'b01, 0);
    step(0, 2'b00, 1, 2'b10, 0);
    step(0, 2'b00, 1, 2'b00, 0);
    chk("s2_pass", a_pass, 2);
    chk("s2_fail", a_fail, 1);
    chk("s2_first_idx", a_idx, 2);
    chk("s2_first_exp", a_fexp, 3);
    chk("s2_first_obs", a_fobs, 0);
    chk("s2_pending", a_pending, 0);
    $display("scenario 2 (ordered compare) done");

    // Overflow: ninth push dropped.
    step(0, 2'b00, 0, 2'b00, 1);
    for (int j = 0; j < 9; j++) step(1, 2'(j % 4), 0, 2'b00, 0);
    chk("s3_pending_full", a_pending, 8);
    chk("s3_overflow", a_ovf, 1);
    for (int j = 0; j < 8; j++) step(0, 2'b00, 1, 2'(j % 4), 0);
    chk("s3_pass", a_pass, 8);
    chk("s3_pending_empty", a_pending, 0);
    $display("scenario 3 (overflow) done");

    // Underflow then bypass.
    step(0, 2'b00, 0, 2'b00, 1);
    step(0, 2'b00, 1, 2'b10, 0);
    chk("s4_underflow", a_unf, 1);
    chk("s4_pass0", a_pass, 0);
    chk("s4_fail0", a_fail, 0);
    step(1, 2'b10, 1, 2'b10, 0);
    chk("s4_pass1", a_pass, 1);
    chk("s4_pending", a_pending, 0);
    $display("scenario 4 (underflow, bypass) done");

    // Full FIFO streaming push+pop; first_* held after a second mismatch.
    step(0, 2'b00, 0, 2'b00, 1);
    for (int j = 0; j < 8; j++) step(1, wv(j), 0, 2'b00, 0);
    for (int k = 0; k < 20; k++) begin
      logic [1:0] o;
      o = wv(k);
      if (k == 0 || k == 15) o = ~o;
      step(1, wv(8 + k), 1, o, 0);
    end
    chk("s5_pending", a_pending, 8);
    chk("s5_overflow", a_ovf, 0);
    chk("s5_pass", a_pass, 18);
    chk("s5_fail", a_fail, 2);
    chk("s5_first_idx", a_idx, 0);
    chk("s5_first_exp", a_fexp, 1);
    chk("s5_first_obs", a_fobs, 2);
    $display("scenario 5 (full streaming) done");

    // Saturation on the 4-bit instance, then clear with concurrent activity.
    step(0, 2'b00, 0, 2'b00, 1);
    for (int k = 0; k < 17; k++) step(1, 2'(k % 4), 1, 2'(k % 4), 0);
    chk("s6_b_pass_sat", b_pass, 15);
    chk("s6_a_pass", a_pass, 17);
    step(1, 2'b01, 1, 2'b10, 0);
    chk("s6_b_idx_sat", b_idx, 15);
    chk("s6_a_idx", a_idx, 17);
    step(1, 2'b01, 1, 2'b10, 1);
    chk("s6_clr_a_pass", a_pass, 0);
    chk("s6_clr_b_pass", b_pass, 0);
    chk("s6_clr_a_fail", a_fail, 0);
    chk("s6_clr_a_seen", a_seen, 0);
    chk("s6_clr_pending", a_pending, 0);
    $display("scenario 6 (saturation, clear) done");

    // Randomised traffic: push-heavy then pop-heavy phases.
    for (int n = 0; n < 2400; n++) begin
      bit ev, ov, clr;
      logic [1:0] ed, od;
      clr = ($urandom_range(0, 63) == 0);
      if (n < 1200) begin
        ev = ($urandom_range(0, 3) != 0);
        ov = ($urandom_range(0, 1) != 0);
      end else begin
        ev = ($urandom_range(0, 1) != 0);
        ov = ($urandom_range(0, 3) != 0);
      end
      ed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) od = (m_q.size() > 0) ? 2'(m_q[0]) : ed;
      else od = 2'($urandom_range(0, 3));
      step(ev, ed, ov, od, clr);
    end
    $display("random phase done");

    step(0, 2'b00, 0, 2'b00, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
